minrv32: RTL and testbench
==========================

MINRV32 -- requirements
Module: minrv32

Interface
REQ-001 Parameters, default, meaning:
- BARREL_SHIFTER, 1, single-level shifter when 1, log-stage shifter when 0; results identical either way.
- ENABLE_FAST_MUL, 1, MUL/MULH/MULHSU/MULHU supported; 0 makes them illegal.
- ENABLE_DIV, 1, DIV/DIVU/REM/REMU supported; 0 makes them illegal.
- PROGADDR_RESET, 32'h10000, pc_next value during reset.
- STACKADDR, 32'h10000, x2 value written during reset.

REQ-002 Ports, direction, width, meaning; the clock is clk and the reset is resetn, synchronous, active-low:
- clk in 1, clock.
- resetn in 1, reset.
- trap out 1, sticky halt flag.
- mem_valid out 1, load/store access active.
- mem_instr out 1, always 0.
- mem_ready in 1, data access complete.
- mem_addr out 32, word-aligned data address.
- mem_wdata out 32, store data, replicated into byte lanes.
- mem_wstrb out 4, store byte-lane enables.
- mem_rmask out 4, load byte-lane enables.
- mem_rdata in 32, load data, combinational.
- pc in 32, current PC, held in an external register.
- pc_next out 32, next PC.
- insn_addr out 32, instruction fetch address, equal to pc.
- insn in 32, instruction word, combinational.
- csr_cycle, csr_time, csr_instret in 64 each, counter values.
- rs1_addr, rs2_addr out 5, register read addresses; rs1_addr_valid and rs2_addr_valid out 1, read used.
- rs1_rdata, rs2_rdata in 32, external register-file data.
- rd_addr out 5, rd_addr_valid out 1, rd_wdata out 32, register write port.

Function
REQ-003 Single-cycle RV32I(M) datapath: one instruction per clk while mem_ready=1; all outputs except trap are combinational.
REQ-004 Read data SHALL be forced to 0 when rs1_addr or rs2_addr is 0, because external x0 is not guaranteed to hold 0.
REQ-005 rd_addr_valid SHALL be 1 only for instructions that write rd, with rd≠0, not trapping, and not stalled.
REQ-006 pc_next SHALL be pc+4 by default; branch target = pc+immB when taken; JAL target = pc+immJ; JALR target = (rs1+immI)&~1; link value = pc+4.
REQ-007 Load/store effective address ea = rs1+imm; mem_addr = ea&~3; lanes are selected by ea[1:0]; byte/half data is shifted into position.
REQ-008 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected lanes of mem_rdata.
REQ-009 Halfword access with ea[0]=1, or word access with ea[1:0]≠0, SHALL be a misaligned trap.
REQ-010 mem_valid=1 for loads/stores; if mem_ready=0 the core stalls: pc_next=pc, rd_addr_valid=0, and mem_wstrb is held.
REQ-011 Shifts SHALL use amount [4:0]; SLT/SLTU per ISA; arithmetic wraps modulo 2^32.
REQ-012 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder = dividend; 0x80000000 / -1 SHALL return quotient 0x80000000 and remainder 0.
REQ-013 Illegal opcode, ECALL, EBREAK, misalignment, or a disabled M instruction SHALL trap: in that cycle writes are suppressed and pc_next=pc; trap goes to 1 at the next edge and stays set.
REQ-014 While trap=1: pc_next=pc, rd_addr_valid=0, mem_valid=0, mem_wstrb=0, mem_rmask=0.
REQ-015 FENCE SHALL execute as a NOP.

Reset
REQ-016 While resetn=0: trap cleared at the edge; pc_next=PROGADDR_RESET; rd_addr_valid=1, rd_addr=2, rd_wdata=STACKADDR; mem_valid=0, mem_wstrb=0, mem_rmask=0.
REQ-017 Reset asserted mid-stall SHALL abandon the access with no write.

Configuration
REQ-018 MINRV32_CSR_EN defined: CSRRS with rs1=x0 reading 0xC00/0xC80 (cycle), 0xC01/0xC81 (time), or 0xC02/0xC82 (instret) SHALL return the low/high word; any other CSR access traps.
REQ-019 MINRV32_CSR_EN undefined: all SYSTEM instructions except FENCE trap.

Structure
REQ-020 Package minrv32_pkg SHALL hold opcode, funct3/funct7, and CSR address constants.
REQ-021 One sub-module, minrv32_muldiv: combinational MUL*/DIV*/REM*.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset with resetn=0 → pc_next=0x10000, x2 write of 0x10000, trap=0.
- ADDI x1,x0,-1 then SRAI x2,x1,4 → rd_wdata 0xFFFFFFFF, then 0xFFFFFFFF.
- SB of 0x41 to 0x10000003 → mem_addr 0x10000000, wstrb 4'b1000, wdata[31:24]=0x41; then LB → 0x00000041.
- BEQ taken at pc=0x10010 with offset -16 → pc_next=0x10000.
- DIV by zero → 0xFFFFFFFF; MULH 0x80000000×0x80000000 → 0x40000000.
- EBREAK → pc_next=pc, no writes, trap=1 next cycle and held until reset.

Source files
------------

// File: rtl/minrv32_pkg.sv
// Shared decode constants for the minrv32 single-cycle RV32I(M) core.
package minrv32_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] F3_CSRRS = 3'b010;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  // Left shifts reuse the right shifter on a bit-reversed operand.
  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

endpackage

// File: rtl/minrv32_muldiv.sv
// Combinational MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit.
module minrv32_muldiv
  import minrv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] prod;
  logic               div_signed, a_neg, b_neg;
  logic [31:0]        abs_a, abs_b, div_b, uq, ur, quot, rem;
  logic               unused_prod;

  assign unused_prod = ^prod[65:64];

  // 33-bit operands let one signed multiplier cover all three high-word flavours.
  always_comb begin
    mul_a = {(funct3 != F3_MULHU) & a[31], a};
    mul_b = {(funct3 == F3_MULH) & b[31], b};
    prod  = 66'(mul_a) * 66'(mul_b);
  end

  // Sign-magnitude divide; the -2^31/-1 case falls out naturally as 0x80000000 rem 0.
  always_comb begin
    div_signed = ~funct3[0];
    a_neg      = div_signed & a[31];
    b_neg      = div_signed & b[31];
    abs_a      = a_neg ? (32'd0 - a) : a;
    abs_b      = b_neg ? (32'd0 - b) : b;
    div_b      = (b == 32'd0) ? 32'd1 : abs_b;
    uq         = abs_a / div_b;
    ur         = abs_a % div_b;
    quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem        = a_neg ? (32'd0 - ur) : ur;
    if (b == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = a;
    end
  end

  always_comb begin
    result = 32'd0;
    case (funct3)
      F3_MUL:                       result = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[63:32];
      F3_DIV, F3_DIVU:              result = quot;
      default:                      result = rem;
    endcase
  end

endmodule

// File: rtl/minrv32.sv
// Single-cycle RV32I(M) core with external PC and register file.
// Define MINRV32_CSR_EN to enable read-only cycle/time/instret CSR access.
module minrv32
  import minrv32_pkg::*;
#(
  parameter int unsigned BARREL_SHIFTER  = 1,
  parameter int unsigned ENABLE_FAST_MUL = 1,
  parameter int unsigned ENABLE_DIV      = 1,
  parameter logic [31:0] PROGADDR_RESET  = 32'h0001_0000,
  parameter logic [31:0] STACKADDR       = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        trap,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [3:0]  mem_rmask,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic [31:0] insn_addr,
  input  logic [31:0] insn,
  input  logic [63:0] csr_cycle,
  input  logic [63:0] csr_time,
  input  logic [63:0] csr_instret,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic        rs1_addr_valid,
  output logic        rs2_addr_valid,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  output logic [4:0]  rd_addr,
  output logic        rd_addr_valid,
  output logic [31:0] rd_wdata
);

  opcode_e     opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  assign opcode   = opcode_e'(insn[6:0]);
  assign rd       = insn[11:7];
  assign funct3   = insn[14:12];
  assign funct7   = insn[31:25];
  assign imm_i    = {{20{insn[31]}}, insn[31:20]};
  assign imm_s    = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u    = {insn[31:12], 12'd0};
  assign imm_j    = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
  assign rs1_addr = insn[19:15];
  assign rs2_addr = insn[24:20];
  // The external register file may not hold zero in x0.
  assign rs1_val  = (rs1_addr == 5'd0) ? 32'd0 : rs1_rdata;
  assign rs2_val  = (rs2_addr == 5'd0) ? 32'd0 : rs2_rdata;
  assign pc_plus4 = pc + 32'd4;

  assign mem_instr = 1'b0;
  assign insn_addr = pc;

  // Shifter: operand is pre-reversed for left shifts so only a right shifter is needed.
  logic [31:0] alu_b, sh_in, sh_raw, sh_res;
  logic [4:0]  shamt;
  logic        sh_left, sh_fill;

  assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign shamt   = alu_b[4:0];
  assign sh_left = (funct3 == F3_SLL);
  assign sh_fill = ~sh_left & insn[30] & rs1_val[31];
  assign sh_in   = sh_left ? rev32(rs1_val) : rs1_val;
  assign sh_res  = sh_left ? rev32(sh_raw) : sh_raw;

  if (BARREL_SHIFTER != 0) begin : g_barrel
    assign sh_raw = 32'($signed({sh_fill, sh_in}) >>> shamt);
  end else begin : g_log
    logic [31:0] st [6];
    assign st[0] = sh_in;
    for (genvar i = 0; i < 5; i++) begin : g_stage
      assign st[i+1] = shamt[i] ? {{(2**i){sh_fill}}, st[i][31:2**i]} : st[i];
    end
    assign sh_raw = st[5];
  end

  logic [31:0] alu_res;
  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      F3_ADD:        alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      F3_SLL, F3_SR: alu_res = sh_res;
      F3_SLT:        alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      F3_SLTU:       alu_res = {31'd0, rs1_val < alu_b};
      F3_XOR:        alu_res = rs1_val ^ alu_b;
      F3_OR:         alu_res = rs1_val | alu_b;
      default:       alu_res = rs1_val & alu_b;
    endcase
  end

  logic [31:0] md_res;
  minrv32_muldiv u_muldiv (
    .funct3 (funct3),
    .a      (rs1_val),
    .b      (rs2_val),
    .result (md_res)
  );

  // Load/store addressing, lane selection and data alignment.
  logic [31:0] ea, ld_sh, ld_val, st_data;
  logic [3:0]  lane_mask;
  logic        misalign;

  always_comb begin
    ea      = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    ld_sh   = mem_rdata >> {ea[1:0], 3'b000};
    case (funct3[1:0])
      2'b00:   begin lane_mask = 4'b0001 << ea[1:0];         st_data = {4{rs2_val[7:0]}};  end
      2'b01:   begin lane_mask = 4'b0011 << {ea[1], 1'b0};   st_data = {2{rs2_val[15:0]}}; end
      default: begin lane_mask = 4'b1111;                    st_data = rs2_val;            end
    endcase
    misalign = ((funct3[1:0] == 2'b01) && ea[0]) || ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    case (funct3)
      F3_LB:   ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_LH:   ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_LBU:  ld_val = {24'd0, ld_sh[7:0]};
      F3_LHU:  ld_val = {16'd0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

`ifdef MINRV32_CSR_EN
  logic        csr_hit;
  logic [31:0] csr_val;
  always_comb begin
    csr_hit = 1'b1;
    csr_val = 32'd0;
    case (insn[31:20])
      CSR_CYCLE:    csr_val = csr_cycle[31:0];
      CSR_CYCLEH:   csr_val = csr_cycle[63:32];
      CSR_TIME:     csr_val = csr_time[31:0];
      CSR_TIMEH:    csr_val = csr_time[63:32];
      CSR_INSTRET:  csr_val = csr_instret[31:0];
      CSR_INSTRETH: csr_val = csr_instret[63:32];
      default:      csr_hit = 1'b0;
    endcase
  end
`else
  logic unused_csr;
  assign unused_csr = ^{csr_cycle, csr_time, csr_instret};
`endif

  // Main decode: write-back value, control flow and legality.
  logic        illegal, wr_en, jump, is_load, is_store;
  logic [31:0] wdata, jump_tgt;

  always_comb begin
    illegal        = 1'b0;
    wr_en          = 1'b0;
    jump           = 1'b0;
    is_load        = 1'b0;
    is_store       = 1'b0;
    wdata          = alu_res;
    jump_tgt       = pc + imm_b;
    rs1_addr_valid = 1'b0;
    rs2_addr_valid = 1'b0;
    case (opcode)
      OPC_LUI:   begin wr_en = 1'b1; wdata = imm_u; end
      OPC_AUIPC: begin wr_en = 1'b1; wdata = pc + imm_u; end
      OPC_JAL: begin
        wr_en = 1'b1; wdata = pc_plus4; jump = 1'b1; jump_tgt = pc + imm_j;
      end
      OPC_JALR: begin
        rs1_addr_valid = 1'b1;
        illegal  = (funct3 != 3'b000);
        wr_en    = 1'b1; wdata = pc_plus4; jump = 1'b1;
        jump_tgt = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        rs1_addr_valid = 1'b1; rs2_addr_valid = 1'b1;
        case (funct3)
          F3_BEQ:  jump = (rs1_val == rs2_val);
          F3_BNE:  jump = (rs1_val != rs2_val);
          F3_BLT:  jump = ($signed(rs1_val) < $signed(rs2_val));
          F3_BGE:  jump = ($signed(rs1_val) >= $signed(rs2_val));
          F3_BLTU: jump = (rs1_val < rs2_val);
          F3_BGEU: jump = (rs1_val >= rs2_val);
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        rs1_addr_valid = 1'b1;
        is_load = 1'b1; wr_en = 1'b1; wdata = ld_val;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        rs1_addr_valid = 1'b1; rs2_addr_valid = 1'b1;
        is_store = 1'b1;
        illegal  = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        rs1_addr_valid = 1'b1;
        wr_en = 1'b1;
        if (funct3 == F3_SLL) illegal = (funct7 != F7_BASE);
        if (funct3 == F3_SR)  illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_OP: begin
        rs1_addr_valid = 1'b1; rs2_addr_valid = 1'b1;
        wr_en = 1'b1;
        if (funct7 == F7_MULDIV) begin
          wdata   = md_res;
          illegal = funct3[2] ? (ENABLE_DIV == 0) : (ENABLE_FAST_MUL == 0);
        end else if (funct7 == F7_ALT) begin
          illegal = (funct3 != F3_ADD) && (funct3 != F3_SR);
        end else begin
          illegal = (funct7 != F7_BASE);
        end
      end
      OPC_MISC_MEM: ;
`ifdef MINRV32_CSR_EN
      OPC_SYSTEM: begin
        rs1_addr_valid = 1'b1;
        wdata = csr_val;
        if (funct3 == F3_CSRRS && rs1_addr == 5'd0 && csr_hit) wr_en = 1'b1;
        else illegal = 1'b1;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

  logic trap_now, mem_access, stall;

  assign trap_now = illegal | ((is_load | is_store) & misalign);

  // Output steering: reset and trap override the decoded instruction.
  always_comb begin
    mem_access = (is_load | is_store) & ~trap_now & ~trap & resetn;
    stall      = mem_access & ~mem_ready;
    mem_valid  = mem_access;
    mem_addr   = {ea[31:2], 2'b00};
    mem_wdata  = st_data;
    mem_wstrb  = (mem_access & is_store) ? lane_mask : 4'b0000;
    mem_rmask  = (mem_access & is_load) ? lane_mask : 4'b0000;
    rd_addr       = rd;
    rd_wdata      = wdata;
    rd_addr_valid = wr_en & (rd != 5'd0) & ~trap_now & ~trap & ~stall;
    if (trap | trap_now | stall) pc_next = pc;
    else if (jump)               pc_next = jump_tgt;
    else                         pc_next = pc_plus4;
    if (!resetn) begin
      pc_next       = PROGADDR_RESET;
      rd_addr       = 5'd2;
      rd_wdata      = STACKADDR;
      rd_addr_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)       trap <= 1'b0;
    else if (trap_now) trap <= 1'b1;
  end

endmodule

// File: tb/tb_minrv32.sv
// Directed bench for minrv32: drives pc/insn/register data, checks combinational outputs.
module tb_minrv32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        trap, mem_valid, mem_instr;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb, mem_rmask;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] pc = 32'h0001_0000;
  logic [31:0] pc_next, insn_addr;
  logic [31:0] insn = 32'h0000_0013;
  logic [63:0] csr_cycle = 64'h0000_0005_0000_00AA;
  logic [63:0] csr_time = 64'd0;
  logic [63:0] csr_instret = 64'd0;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_addr_valid, rs2_addr_valid, rd_addr_valid;
  logic [31:0] rs1_rdata = 32'd0;
  logic [31:0] rs2_rdata = 32'd0;
  logic [31:0] rd_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  minrv32 dut (
    .clk(clk), .resetn(resetn), .trap(trap),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
    .pc(pc), .pc_next(pc_next), .insn_addr(insn_addr), .insn(insn),
    .csr_cycle(csr_cycle), .csr_time(csr_time), .csr_instret(csr_instret),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_addr_valid(rs1_addr_valid), .rs2_addr_valid(rs2_addr_valid),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .rd_addr(rd_addr), .rd_addr_valid(rd_addr_valid), .rd_wdata(rd_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one instruction at the falling edge and let the combinational outputs settle.
  task automatic step(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    insn = i; pc = p; rs1_rdata = a; rs2_rdata = b;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; mem_ready = 1'b1; insn = 32'h0000_0013;
    #1;
    check("rst_pc_next", pc_next, 32'h0001_0000);
    check("rst_rd_valid", 32'(rd_addr_valid), 32'd1);
    check("rst_rd_addr", 32'(rd_addr), 32'd2);
    check("rst_rd_wdata", rd_wdata, 32'h0001_0000);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    check("rst_trap", 32'(trap), 32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    do_reset();

    // ALU / immediates; rs1_rdata garbage for x0 must be ignored
    step(32'hFFF0_0093, 32'h0001_0000, 32'h1234_5678, 32'd0);    // addi x1,x0,-1
    check("addi_wdata", rd_wdata, 32'hFFFF_FFFF);
    check("addi_rd", 32'(rd_addr), 32'd1);
    check("addi_valid", 32'(rd_addr_valid), 32'd1);
    check("addi_pc_next", pc_next, 32'h0001_0004);
    step(32'h4040_D113, 32'h0001_0004, 32'hFFFF_FFFF, 32'd0);    // srai x2,x1,4
    check("srai_ones", rd_wdata, 32'hFFFF_FFFF);
    step(32'h4040_D113, 32'h0001_0008, 32'h8000_0000, 32'd0);
    check("srai_sign", rd_wdata, 32'hF800_0000);
    step(32'h0040_D113, 32'h0001_0008, 32'h8000_0000, 32'd0);    // srli x2,x1,4
    check("srli", rd_wdata, 32'h0800_0000);
    step(32'h01F0_9193, 32'h0001_0008, 32'h0000_0003, 32'd0);    // slli x3,x1,31
    check("slli", rd_wdata, 32'h8000_0000);
    step(32'h4020_81B3, 32'h0001_0008, 32'd5, 32'd7);            // sub x3,x1,x2
    check("sub", rd_wdata, 32'hFFFF_FFFE);
    step(32'h0020_A1B3, 32'h0001_0008, 32'hFFFF_FFFF, 32'd1);    // slt
    check("slt", rd_wdata, 32'd1);
    step(32'h0020_B1B3, 32'h0001_0008, 32'hFFFF_FFFF, 32'd1);    // sltu
    check("sltu", rd_wdata, 32'd0);
    step(32'h1234_5237, 32'h0001_0008, 32'd0, 32'd0);            // lui x4
    check("lui", rd_wdata, 32'h1234_5000);
    step(32'h0080_00EF, 32'h0001_0000, 32'd0, 32'd0);            // jal x1,+8
    check("jal_link", rd_wdata, 32'h0001_0004);
    check("jal_pc_next", pc_next, 32'h0001_0008);
    step(32'h0051_80E7, 32'h0001_0000, 32'h0000_2000, 32'd0);    // jalr x1,5(x3)
    check("jalr_pc_next", pc_next, 32'h0000_2004);
    step(32'h0000_000F, 32'h0001_0000, 32'd0, 32'd0);            // fence
    check("fence_pc_next", pc_next, 32'h0001_0004);
    check("fence_trap_next", 32'(trap), 32'd0);

    // Byte store to the top lane, then the matching loads
    step(32'h0020_81A3, 32'h0001_0000, 32'h1000_0000, 32'h0000_0041);  // sb x2,3(x1)
    check("sb_valid", 32'(mem_valid), 32'd1);
    check("sb_addr", mem_addr, 32'h1000_0000);
    check("sb_wstrb", 32'(mem_wstrb), 32'h8);
    check("sb_wdata_b3", 32'(mem_wdata[31:24]), 32'h41);
    check("sb_no_rd", 32'(rd_addr_valid), 32'd0);
    mem_ready = 1'b0; #1;
    check("stall_pc_next", pc_next, 32'h0001_0000);
    check("stall_wstrb", 32'(mem_wstrb), 32'h8);
    mem_ready = 1'b1; mem_rdata = 32'h4100_0000;
    step(32'h0030_8283, 32'h0001_0004, 32'h1000_0000, 32'd0);    // lb x5,3(x1)
    check("lb_data", rd_wdata, 32'h0000_0041);
    check("lb_rmask", 32'(mem_rmask), 32'h8);
    mem_rdata = 32'h8000_0000; #1;
    check("lb_sext", rd_wdata, 32'hFFFF_FF80);
    step(32'h0030_C283, 32'h0001_0004, 32'h1000_0000, 32'd0);    // lbu
    check("lbu_zext", rd_wdata, 32'h0000_0080);
    mem_rdata = 32'hBEEF_0000;
    step(32'h0020_D283, 32'h0001_0004, 32'h1000_0000, 32'd0);    // lhu x5,2(x1)
    check("lhu", rd_wdata, 32'h0000_BEEF);
    check("lhu_rmask", 32'(mem_rmask), 32'hC);

    // Branches
    step(32'hFE20_88E3, 32'h0001_0010, 32'd5, 32'd5);            // beq -16
    check("beq_taken", pc_next, 32'h0001_0000);
    step(32'hFE20_88E3, 32'h0001_0010, 32'd5, 32'd6);
    check("beq_not_taken", pc_next, 32'h0001_0014);

    // Multiply / divide
    step(32'h0220_C1B3, 32'h0001_0000, 32'd7, 32'd0);            // div /0
    check("div_by_zero", rd_wdata, 32'hFFFF_FFFF);
    step(32'h0220_E1B3, 32'h0001_0000, 32'd7, 32'd0);            // rem /0
    check("rem_by_zero", rd_wdata, 32'd7);
    step(32'h0220_C1B3, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", rd_wdata, 32'h8000_0000);
    step(32'h0220_E1B3, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_overflow", rd_wdata, 32'd0);
    step(32'h0220_C1B3, 32'h0001_0000, 32'hFFFF_FFF9, 32'd2);    // -7/2
    check("div_neg", rd_wdata, 32'hFFFF_FFFD);
    step(32'h0220_E1B3, 32'h0001_0000, 32'hFFFF_FFF9, 32'd2);
    check("rem_neg", rd_wdata, 32'hFFFF_FFFF);
    step(32'h0220_91B3, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000);  // mulh
    check("mulh", rd_wdata, 32'h4000_0000);
    step(32'h0220_A1B3, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000);  // mulhsu
    check("mulhsu", rd_wdata, 32'hC000_0000);
    step(32'h0220_81B3, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  // mul
    check("mul_low", rd_wdata, 32'd1);

    // Reset during a stalled store abandons it
    mem_ready = 1'b0;
    step(32'h0020_81A3, 32'h0001_0000, 32'h1000_0000, 32'h0000_0041);
    check("pre_rst_stall_wstrb", 32'(mem_wstrb), 32'h8);
    resetn = 1'b0; #1;
    check("rst_stall_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_stall_valid", 32'(mem_valid), 32'd0);
    do_reset();

    // Misaligned word store traps
    step(32'h0020_A123, 32'h0001_0020, 32'h1000_0000, 32'h1234_5678);  // sw x2,2(x1)
    check("mis_wstrb", 32'(mem_wstrb), 32'h0);
    check("mis_valid", 32'(mem_valid), 32'd0);
    check("mis_pc_next", pc_next, 32'h0001_0020);
    @(negedge clk);
    check("mis_trap", 32'(trap), 32'd1);
    do_reset();

    // rdcycle: readable only with the CSR option
    step(32'hC000_2173, 32'h0001_0000, 32'd0, 32'd0);
`ifdef MINRV32_CSR_EN
    check("csr_cycle", rd_wdata, 32'h0000_00AA);
    check("csr_valid", 32'(rd_addr_valid), 32'd1);
`else
    check("csr_no_rd", 32'(rd_addr_valid), 32'd0);
    check("csr_pc_next", pc_next, 32'h0001_0000);
    @(negedge clk);
    check("csr_trap", 32'(trap), 32'd1);
    do_reset();
`endif

    // EBREAK: trap is sticky until reset
    step(32'h0010_0073, 32'h0001_0040, 32'd0, 32'd0);
    check("ebreak_pc_next", pc_next, 32'h0001_0040);
    check("ebreak_no_rd", 32'(rd_addr_valid), 32'd0);
    check("ebreak_no_mem", 32'(mem_valid), 32'd0);
    check("ebreak_trap_same", 32'(trap), 32'd0);
    step(32'hFFF0_0093, 32'h0001_0040, 32'd0, 32'd0);
    check("ebreak_trap_set", 32'(trap), 32'd1);
    check("trapped_no_rd", 32'(rd_addr_valid), 32'd0);
    check("trapped_pc_next", pc_next, 32'h0001_0040);
    step(32'h0020_81A3, 32'h0001_0040, 32'h1000_0000, 32'h41);
    check("trapped_no_mem", 32'(mem_valid), 32'd0);
    check("trapped_no_wstrb", 32'(mem_wstrb), 32'h0);
    repeat (3) @(negedge clk);
    check("trap_held", 32'(trap), 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, elapsed %0t", $time);
    $fatal(1);
  end

endmodule
